load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage fed by the decoder's Load/Store/fun3 outputs, the ALU address and the rs2 data.
- Runs a req/gnt/rvalid handshake to a 32-bit data memory.
- Generates byte strobes and lane-replicated write data.
- Returns sign- or zero-extended load data to writeback, and stalls the core while an access is in flight.

Parameters:
- DATA_WIDTH, 32, data and address width (only 32 supported).
- FUNCTION3, 3, fun3 width.
- TIMEOUT_CYCLES, 16, maximum wait cycles in REQ or WAIT (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- load_i  in  1  load instruction in this stage.
- store_i  in  1  store instruction in this stage.
- fun3_i  in  3  access size and sign.
- addr_i  in  32  effective address from the ALU.
- wdata_i  in  32  store data (rs2).
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  word address, bits [1:0] forced to 0.
- mem_wstrb_o  out  4  byte write strobes.
- mem_wdata_o  out  32  lane-replicated write data.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  raw read word.
- rdata_o  out  32  extended load result.
- rdata_valid_o  out  1  rdata_o valid (one cycle).
- done_o  out  1  access completed (one cycle).
- stall_o  out  1  freeze upstream pipeline.
- err_o  out  1  misaligned access, illegal fun3 or timeout (one cycle).

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Registered outputs reset to 0: mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o, rdata_o, rdata_valid_o, done_o, err_o. State resets to IDLE.
- FSM states: IDLE, REQ, WAIT, RESP, ERR.
- IDLE, access start:
  - A cycle with load_i or store_i set starts an access.
  - If both are set, the store wins and the load is ignored.
  - Address, fun3, write data and direction are latched on the start edge. Upstream must hold these inputs until stall_o falls.
- IDLE, error check:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal fun3: load 011/110/111, store 011..111.
  - Either case → ERR, with no memory request.
  - Otherwise → REQ.
- stall_o (combinational) = start-in-IDLE OR state in {REQ, WAIT}. It is 0 in RESP and ERR.
- REQ:
  - mem_req_o=1; addr, we, wstrb and wdata held stable until mem_gnt_i.
  - Store + gnt → RESP. Load + gnt → WAIT.
  - mem_req_o falls the cycle after gnt.
- WAIT: on mem_rvalid_i, capture the extended data into rdata_o → RESP. rvalid in the same cycle as gnt is not supported; rvalid arrives ≥1 cycle after gnt.
- RESP: done_o=1; rdata_valid_o=1 for loads only; → IDLE.
- ERR: err_o=1 for one cycle → IDLE. The register file must not be written.
- Store strobes and data:
  - sb: wstrb = 0001<<addr[1:0], wdata = 4 copies of wdata_i[7:0].
  - sh: wstrb = 0011<<addr[1:0], wdata = 2 copies of wdata_i[15:0].
  - sw: wstrb = 1111, wdata = wdata_i.
  - mem_wstrb_o = 0 for loads.
- Load extraction: word shifted right by 8*addr[1:0], then
  - 000 sign-extend byte;
  - 001 sign-extend halfword;
  - 010 full word;
  - 100 zero-extend byte;
  - 101 zero-extend halfword.
- Latency, zero-wait memory: store = 3 cycles from start to done_o; load = 4 cycles.
- Back-to-back: a new access may start in the cycle after RESP (IDLE). There is no overlap of accesses.
- Reset mid-access: state → IDLE and mem_req_o=0 on the reset edge. A stray rvalid or gnt arriving in IDLE is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter cleared on entry to REQ or WAIT increments each cycle spent there.
  - Reaching TIMEOUT_CYCLES → ERR (err_o pulse), mem_req_o dropped, stall released.
- Undefined: no counter; the FSM waits indefinitely for gnt/rvalid.

Test Plan:
- SB to addr 0x103, wdata 0xAABBCCDD, gnt on first REQ cycle → mem_addr 0x100, wstrb 1000, wdata 0xDDDDDDDD, done_o at cycle 3, stall_o high for cycles 1-2.
- LB at 0x101, rdata 0x0000F700, gnt then rvalid next cycle → rdata_o 0xFFFFFFF7, rdata_valid_o for one cycle at cycle 4; LBU at the same address → 0x000000F7.
- LH at 0x102, rdata 0x80010000 → rdata_o 0xFFFF8001; LW at 0x006 → err_o pulse, mem_req_o never asserts.
- SW to 0x200 with gnt withheld 5 cycles → mem_req_o, mem_addr and wdata stable for all 5 cycles; done_o 1 cycle after gnt; stall_o high throughout.
- Load in WAIT, rst asserted → next cycle IDLE, mem_req_o=0; rvalid after reset produces no rdata_valid_o.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, LW with no gnt → err_o after 16 REQ cycles, stall_o falls, FSM returns to IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and writeback.
// Drives a req/gnt/rvalid handshake to a 32-bit data memory. It builds byte strobes and
// lane-replicated store data, and returns sign- or zero-extended load data.
// It holds stall_o high while an access is in flight.
// Optional feature: define LSU_TIMEOUT_EN to abort an access stuck in REQ or WAIT
// after TIMEOUT_CYCLES cycles; without it the FSM waits indefinitely.
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int FUNCTION3      = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  store_i,
    input  logic [FUNCTION3-1:0]  fun3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_wstrb_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic                  done_o,
    output logic                  stall_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_t;

    state_t               state;
    state_t               state_next;
    logic                 start;
    logic                 misaligned;
    logic                 illegal;
    logic                 bad_access;
    logic                 timed_out;
    logic [FUNCTION3-1:0] fun3_q;
    logic [1:0]           offset_q;

    // Byte strobes for a store of the given size at the given byte offset.
    function automatic logic [3:0] strobe_for(input logic [FUNCTION3-1:0] f3,
                                              input logic [1:0] off);
        case (f3[1:0])
            2'b00:   strobe_for = 4'b0001 << off;
            2'b01:   strobe_for = 4'b0011 << off;
            default: strobe_for = 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across every lane it could land in.
    function automatic logic [DATA_WIDTH-1:0] wdata_for(input logic [FUNCTION3-1:0] f3,
                                                        input logic [DATA_WIDTH-1:0] wd);
        case (f3[1:0])
            2'b00:   wdata_for = {4{wd[7:0]}};
            2'b01:   wdata_for = {2{wd[15:0]}};
            default: wdata_for = wd;
        endcase
    endfunction

    // Move the addressed lane down to bit 0, then sign- or zero-extend it.
    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [FUNCTION3-1:0] f3,
                                                          input logic [1:0] off,
                                                          input logic [DATA_WIDTH-1:0] word);
        logic [DATA_WIDTH-1:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            3'b000:  load_extend = {{24{s[7]}}, s[7:0]};
            3'b001:  load_extend = {{16{s[15]}}, s[15:0]};
            3'b100:  load_extend = {24'd0, s[7:0]};
            3'b101:  load_extend = {16'd0, s[15:0]};
            default: load_extend = s;
        endcase
    endfunction

    assign start   = (state == IDLE) && (load_i || store_i);
    assign stall_o = start || (state == REQ) || (state == WAIT);

    // Classify the incoming access; a store outranks a simultaneous load.
    always_comb begin
        misaligned = ((fun3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((fun3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        if (store_i) begin
            illegal = fun3_i[2] || (fun3_i[1:0] == 2'b11);
        end else begin
            illegal = (fun3_i == 3'b011) || (fun3_i == 3'b110) || (fun3_i == 3'b111);
        end
        bad_access = misaligned || illegal;
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Count cycles spent in REQ/WAIT, restarting on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if ((state == REQ) || (state == WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: the comparison is constant false, so an access never aborts.
    assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the access handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = bad_access ? ERR : REQ;
            REQ: begin
                if (mem_gnt_i)      state_next = mem_we_o ? RESP : WAIT;
                else if (timed_out) state_next = ERR;
            end
            WAIT: begin
                if (mem_rvalid_i)   state_next = RESP;
                else if (timed_out) state_next = ERR;
            end
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Size and byte offset of the access, needed again when load data returns.
    always_ff @(posedge clk) begin
        if (start) begin
            fun3_q   <= fun3_i;
            offset_q <= addr_i[1:0];
        end
    end

    // Registered memory-side signals and writeback pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wstrb_o   <= 4'b0000;
            mem_wdata_o   <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            done_o        <= 1'b0;
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_access) begin
                            err_o <= 1'b1;
                        end else begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= store_i;
                            mem_addr_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                            mem_wstrb_o <= store_i ? strobe_for(fun3_i, addr_i[1:0]) : 4'b0000;
                            mem_wdata_o <= store_i ? wdata_for(fun3_i, wdata_i) : '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        done_o    <= mem_we_o;
                    end else if (timed_out) begin
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        rdata_o       <= load_extend(fun3_q, offset_q, mem_rdata_i);
                        rdata_valid_o <= 1'b1;
                        done_o        <= 1'b1;
                    end else if (timed_out) begin
                        err_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scenario tasks with a scoreboard queue.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_i;
    logic        store_i;
    logic [2:0]  fun3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        done_o;
    logic        stall_o;
    logic        err_o;

    typedef struct {
        int          lat;
        logic [31:0] data;
        logic        rv;
        logic        err;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          stall;
    } rec_t;

    rec_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst), .load_i(load_i), .store_i(store_i), .fun3_i(fun3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .done_o(done_o),
        .stall_o(stall_o), .err_o(err_o)
    );

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a[1:0])
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s;
        s = 4'b0000;
        case (f3[1:0])
            2'b00: s[a[1:0]] = 1'b1;
            2'b01: begin s[a[1:0]] = 1'b1; s[a[1:0] + 2'd1] = 1'b1; end
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
        case (f3[1:0])
            2'b00:   return {w[7:0], w[7:0], w[7:0], w[7:0]};
            2'b01:   return {w[15:0], w[15:0]};
            default: return w;
        endcase
    endfunction

    // Drives one access from an IDLE cycle and acts as the memory; records what it saw.
    task automatic issue(input logic st, input logic ld, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd_word, input int gdelay, output rec_t o);
        logic pg;
        int   waited;
        o = '{lat: -1, data: 32'd0, rv: 1'b0, err: 1'b0, req: 1'b0, we: 1'b0,
              addr: 32'd0, strb: 4'd0, wdata: 32'd0, stall: 0};
        waited = 0;
        store_i = st; load_i = ld; fun3_i = f3; addr_i = a; wdata_i = wd;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (stall_o) o.stall = o.stall + 1;
            if (mem_req_o && !o.req) begin
                o.req = 1'b1; o.we = mem_we_o; o.addr = mem_addr_o;
                o.strb = mem_wstrb_o; o.wdata = mem_wdata_o;
            end
            if (done_o || err_o) begin
                o.lat = c; o.data = rdata_o; o.rv = rdata_valid_o; o.err = err_o;
                break;
            end
            @(posedge clk); #1;
            pg = mem_gnt_i;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'hDEAD_BEEF;
            if (pg && ld && !st) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = rd_word;
            end else if (mem_req_o) begin
                if (waited >= gdelay) mem_gnt_i = 1'b1;
                waited++;
            end
        end
        store_i = 1'b0; load_i = 1'b0;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
        n_cmp++; if (mem_addr_o !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
        n_cmp++; if (mem_wstrb_o !== 4'd0) begin n_fail++; $display("FAIL reset_strb: got %b want 0", mem_wstrb_o); end
        n_cmp++; if (rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
        n_cmp++; if ({done_o, err_o, rdata_valid_o, stall_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {done_o, err_o, rdata_valid_o, stall_o});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        logic [2:0]  f3s [4] = '{3'b000, 3'b001, 3'b000, 3'b010};
        logic [31:0] as  [4] = '{32'h103, 32'h102, 32'h101, 32'h204};
        logic [31:0] wds [4] = '{32'hAABBCCDD, 32'h1234ABCD, 32'h55667788, 32'h0BADF00D};
        int          gds [4] = '{0, 1, 0, 2};
        rec_t o, e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{lat: 3 + gds[i], data: 32'd0, rv: 1'b0, err: 1'b0, req: 1'b1, we: 1'b1,
                           addr: as[i] & ~32'd3, strb: model_strb(f3s[i], as[i]),
                           wdata: model_wdata(f3s[i], wds[i]), stall: 2 + gds[i]});
            issue(1'b1, 1'b0, f3s[i], as[i], wds[i], 32'd0, gds[i], o);
            e = sb.pop_front();
            n_cmp++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL st%0d_lat: got %0d want %0d", i, o.lat, e.lat); end
            n_cmp++; if (o.we !== e.we) begin n_fail++; $display("FAIL st%0d_we: got %b want %b", i, o.we, e.we); end
            n_cmp++; if (o.addr !== e.addr) begin n_fail++; $display("FAIL st%0d_addr: got %h want %h", i, o.addr, e.addr); end
            n_cmp++; if (o.strb !== e.strb) begin n_fail++; $display("FAIL st%0d_strb: got %b want %b", i, o.strb, e.strb); end
            n_cmp++; if (o.wdata !== e.wdata) begin n_fail++; $display("FAIL st%0d_wdata: got %h want %h", i, o.wdata, e.wdata); end
            n_cmp++; if (o.stall !== e.stall) begin n_fail++; $display("FAIL st%0d_stall: got %0d want %0d", i, o.stall, e.stall); end
            n_cmp++; if (o.rv !== e.rv) begin n_fail++; $display("FAIL st%0d_rvalid: got %b want %b", i, o.rv, e.rv); end
        end
    endtask

    task automatic test_load();
        logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        logic [31:0] as  [6] = '{32'h101, 32'h101, 32'h102, 32'h102, 32'h104, 32'h103};
        logic [31:0] rds [6] = '{32'h0000F700, 32'h0000F700, 32'h80010000, 32'h80010000,
                                 32'h89ABCDEF, 32'h7F000000};
        int          gds [6] = '{0, 0, 0, 0, 1, 0};
        rec_t o, e;
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{lat: 4 + gds[i], data: model_load(f3s[i], as[i], rds[i]), rv: 1'b1,
                           err: 1'b0, req: 1'b1, we: 1'b0, addr: as[i] & ~32'd3, strb: 4'd0,
                           wdata: 32'd0, stall: 3 + gds[i]});
            issue(1'b0, 1'b1, f3s[i], as[i], 32'hFFFFFFFF, rds[i], gds[i], o);
            e = sb.pop_front();
            n_cmp++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL ld%0d_lat: got %0d want %0d", i, o.lat, e.lat); end
            n_cmp++; if (o.data !== e.data) begin n_fail++; $display("FAIL ld%0d_data: got %h want %h", i, o.data, e.data); end
            n_cmp++; if (o.rv !== e.rv) begin n_fail++; $display("FAIL ld%0d_rvalid: got %b want %b", i, o.rv, e.rv); end
            n_cmp++; if (o.addr !== e.addr) begin n_fail++; $display("FAIL ld%0d_addr: got %h want %h", i, o.addr, e.addr); end
            n_cmp++; if ({o.we, o.strb} !== {e.we, e.strb}) begin n_fail++; $display("FAIL ld%0d_we_strb: got %b want %b", i, {o.we, o.strb}, {e.we, e.strb}); end
            n_cmp++; if (o.stall !== e.stall) begin n_fail++; $display("FAIL ld%0d_stall: got %0d want %0d", i, o.stall, e.stall); end
        end
        @(negedge clk);
        n_cmp++; if (rdata_valid_o !== 1'b0) begin n_fail++; $display("FAIL ld_rvalid_pulse: got %b want 0", rdata_valid_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        logic        sts [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f3s [6] = '{3'b010, 3'b001, 3'b100, 3'b011, 3'b110, 3'b001};
        logic [31:0] as  [6] = '{32'h006, 32'h101, 32'h100, 32'h100, 32'h100, 32'h003};
        rec_t o, e;
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{lat: 2, data: 32'd0, rv: 1'b0, err: 1'b1, req: 1'b0, we: 1'b0,
                           addr: 32'd0, strb: 4'd0, wdata: 32'd0, stall: 1});
            issue(sts[i], !sts[i], f3s[i], as[i], 32'h12345678, 32'h0, 0, o);
            e = sb.pop_front();
            n_cmp++; if (o.err !== e.err) begin n_fail++; $display("FAIL err%0d_err: got %b want %b", i, o.err, e.err); end
            n_cmp++; if (o.req !== e.req) begin n_fail++; $display("FAIL err%0d_req: got %b want %b", i, o.req, e.req); end
            n_cmp++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL err%0d_lat: got %0d want %0d", i, o.lat, e.lat); end
            n_cmp++; if (o.stall !== e.stall) begin n_fail++; $display("FAIL err%0d_stall: got %0d want %0d", i, o.stall, e.stall); end
        end
    endtask

    task automatic test_store_wins();
        rec_t o;
        issue(1'b1, 1'b1, 3'b010, 32'h300, 32'h01020304, 32'h0, 0, o);
        n_cmp++; if (o.we !== 1'b1) begin n_fail++; $display("FAIL both_we: got %b want 1", o.we); end
        n_cmp++; if (o.strb !== 4'b1111) begin n_fail++; $display("FAIL both_strb: got %b want 1111", o.strb); end
        n_cmp++; if (o.lat !== 3) begin n_fail++; $display("FAIL both_lat: got %0d want 3", o.lat); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3s [8];
        logic [31:0] as  [8];
        logic [31:0] rds [8];
        logic [1:0]  off;
        rec_t o, e;
        for (int i = 0; i < 8; i++) begin
            f3s[i] = legal[$urandom_range(0, 4)];
            case (f3s[i][1:0])
                2'b00:   off = 2'($urandom_range(0, 3));
                2'b01:   off = {1'($urandom_range(0, 1)), 1'b0};
                default: off = 2'b00;
            endcase
            as[i]  = {20'd0, 10'($urandom_range(0, 1023)), off};
            rds[i] = $urandom;
            sb.push_back('{lat: 4, data: model_load(f3s[i], as[i], rds[i]), rv: 1'b1, err: 1'b0,
                           req: 1'b1, we: 1'b0, addr: as[i] & ~32'd3, strb: 4'd0, wdata: 32'd0,
                           stall: 3});
        end
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 1'b1, f3s[i], as[i], 32'h0, rds[i], 0, o);
            e = sb.pop_front();
            n_cmp++; if (o.data !== e.data) begin n_fail++; $display("FAIL b2b%0d_data: got %h want %h", i, o.data, e.data); end
            n_cmp++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL b2b%0d_lat: got %0d want %0d", i, o.lat, e.lat); end
        end
    endtask

    task automatic test_gnt_withheld();
        rec_t e;
        store_i = 1'b1; fun3_i = 3'b010; addr_i = 32'h200; wdata_i = 32'hCAFEF00D;
        sb.push_back('{lat: 8, data: 32'd0, rv: 1'b0, err: 1'b0, req: 1'b1, we: 1'b1,
                       addr: 32'h200, strb: 4'hF, wdata: 32'hCAFEF00D, stall: 7});
        @(negedge clk);
        n_cmp++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL hold_stall_start: got %b want 1", stall_o); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL hold%0d_req: got %b want 1", k, mem_req_o); end
            n_cmp++; if (mem_addr_o !== 32'h200) begin n_fail++; $display("FAIL hold%0d_addr: got %h want 200", k, mem_addr_o); end
            n_cmp++; if (mem_wdata_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL hold%0d_wdata: got %h want cafef00d", k, mem_wdata_o); end
            n_cmp++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL hold%0d_stall: got %b want 1", k, stall_o); end
        end
        @(posedge clk); #1;
        mem_gnt_i = 1'b1;
        @(negedge clk);
        n_cmp++; if ({mem_req_o, stall_o, done_o} !== 3'b110) begin n_fail++; $display("FAIL hold_gnt_cycle: got %b want 110", {mem_req_o, stall_o, done_o}); end
        @(posedge clk); #1;
        mem_gnt_i = 1'b0; store_i = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL hold_done: got %b want 1", done_o); end
        n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL hold_req_drop: got %b want 0", mem_req_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL hold_stall_end: got %b want 0", stall_o); end
        n_cmp++; if (rdata_valid_o !== e.rv) begin n_fail++; $display("FAIL hold_rvalid: got %b want %b", rdata_valid_o, e.rv); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        load_i = 1'b1; fun3_i = 3'b010; addr_i = 32'h100;
        @(posedge clk); #1;
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait_stall: got %b want 1", stall_o); end
        rst = 1'b1; load_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({mem_req_o, stall_o, done_o, rdata_valid_o} !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_idle: got %b want 0000", {mem_req_o, stall_o, done_o, rdata_valid_o});
        end
        mem_rvalid_i = 1'b1; mem_gnt_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
        @(negedge clk);
        n_cmp++; if ({rdata_valid_o, done_o, err_o, mem_req_o} !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_stray: got %b want 0000", {rdata_valid_o, done_o, err_o, mem_req_o});
        end
        n_cmp++; if (rdata_o !== 32'd0) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 0", rdata_o); end
        @(posedge clk); #1;
        store_i = 1'b1; fun3_i = 3'b010; addr_i = 32'h240; wdata_i = 32'h1;
        @(posedge clk); #1;
        rst = 1'b1; store_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL rstreq_before: got %b want 1", mem_req_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({mem_req_o, stall_o} !== 2'b00) begin n_fail++; $display("FAIL rstreq_after: got %b want 00", {mem_req_o, stall_o}); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int   req_cycles;
        logic got_err;
        logic stall_at_err;
        req_cycles = 0; got_err = 1'b0; stall_at_err = 1'b1;
        load_i = 1'b1; fun3_i = 3'b010; addr_i = 32'h400;
`ifdef LSU_TIMEOUT_EN
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_req_o) req_cycles++;
            if (err_o) begin got_err = 1'b1; stall_at_err = stall_o; break; end
            @(posedge clk); #1;
        end
        load_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (req_cycles !== 16) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 16", req_cycles); end
        n_cmp++; if (got_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", got_err); end
        n_cmp++; if (stall_at_err !== 1'b0) begin n_fail++; $display("FAIL to_stall: got %b want 0", stall_at_err); end
        @(negedge clk);
        n_cmp++; if ({mem_req_o, stall_o, err_o} !== 3'b000) begin n_fail++; $display("FAIL to_idle: got %b want 000", {mem_req_o, stall_o, err_o}); end
        @(posedge clk); #1;
`else
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (mem_req_o) req_cycles++;
            if (err_o) got_err = 1'b1;
            @(posedge clk); #1;
        end
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h13579BDF;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0; load_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_cycles !== 20) begin n_fail++; $display("FAIL nto_req_cycles: got %0d want 20", req_cycles); end
        n_cmp++; if (got_err !== 1'b0) begin n_fail++; $display("FAIL nto_err: got %b want 0", got_err); end
        n_cmp++; if (rdata_valid_o !== 1'b1) begin n_fail++; $display("FAIL nto_rvalid: got %b want 1", rdata_valid_o); end
        n_cmp++; if (rdata_o !== 32'h13579BDF) begin n_fail++; $display("FAIL nto_rdata: got %h want 13579bdf", rdata_o); end
        @(posedge clk); #1;
`endif
    endtask

    initial begin
        rst = 1'b1; load_i = 1'b0; store_i = 1'b0; fun3_i = 3'b000; addr_i = 32'd0;
        wdata_i = 32'd0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
        test_reset();
        test_store();
        test_load();
        test_errors();
        test_store_wins();
        test_back_to_back();
        test_gnt_withheld();
        test_reset_mid_access();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
